// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter that shares one 8:1 32-bit multiplexer between eight
// valid/ready requesters and presents the selected word as a single output stream.

module multiplexer (
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [31:0] data4,
  input  logic [31:0] data5,
  input  logic [31:0] data6,
  input  logic [31:0] data7,
  input  logic [2:0]  selectLine,
  output logic [31:0] Output
);
  always_comb begin
    case (selectLine)
      3'd0:    Output = data0;
      3'd1:    Output = data1;
      3'd2:    Output = data2;
      3'd3:    Output = data3;
      3'd4:    Output = data4;
      3'd5:    Output = data5;
      3'd6:    Output = data6;
      default: Output = data7;
    endcase
  end
endmodule

module mux_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  reqValid,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [31:0] data4,
  input  logic [31:0] data5,
  input  logic [31:0] data6,
  input  logic [31:0] data7,
  output logic [7:0]  reqReady,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outData,
  output logic [2:0]  selectLine,
  output logic [7:0]  grant,
  output logic        busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] win;
  logic       win_vld;
  logic       beat;
  logic       last_beat;

  multiplexer u_mux (
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .selectLine(sel_q), .Output(outData)
  );

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (reqValid[ptr_q + 3'(k)]) begin
        win     = ptr_q + 3'(k);
        win_vld = 1'b1;
      end
    end
  end

  assign outValid   = (state_q == GRANT) && reqValid[sel_q];
  assign beat       = outValid && outReady;
  assign reqReady   = grant_q & {8{beat}};
  assign last_beat  = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign selectLine = sel_q;
  assign grant      = grant_q;
  assign busy       = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = 8'(1) << win;
          cnt_d   = '0;
        end
      end
      default: begin
        // A dropped request and a final beat release the same way: one bubble, ptr past holder.
        if (!reqValid[sel_q] || (beat && last_beat)) begin
          state_d = IDLE;
          ptr_d   = sel_q + 3'd1;
          grant_d = '0;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
